// File: rtl/ctrl_pkg.sv
// ctrl_pkg: state, opcode and writeback-select encodings shared by the controller.
package ctrl_pkg;
  typedef enum logic [2:0] {
    S_WAIT   = 3'd0,
    S_DECODE = 3'd1,
    S_WIMM   = 3'd2,
    S_GETA   = 3'd3,
    S_GETB   = 3'd4,
    S_EXEC   = 3'd5,
    S_WREG   = 3'd6
  } state_t;
  typedef enum logic [1:0] {VSEL_C, VSEL_PC, VSEL_IMM8, VSEL_MDATA} vsel_t;
  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;
  localparam logic [1:0] OP_MOVI = 2'b10;
  localparam logic [1:0] OP_MOVR = 2'b00;
  localparam logic [1:0] OP_CMP  = 2'b01;
  localparam logic [1:0] OP_MVN  = 2'b11;
endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: field extraction, instruction class flags and immediate sign extension.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic [15:0]   ir,
  output logic [2:0]    rn,
  output logic [2:0]    rd,
  output logic [2:0]    rm,
  output logic          is_movi,
  output logic          is_movr,
  output logic          is_cmp,
  output logic          is_mvn,
  output logic          legal,
  output logic [DW-1:0] sximm5,
  output logic [DW-1:0] sximm8
);
  logic is_alu;
  assign rn      = ir[10:8];
  assign rd      = ir[7:5];
  assign rm      = ir[2:0];
  assign is_movi = ir[15:13] == OPC_MOV && ir[12:11] == OP_MOVI;
  assign is_movr = ir[15:13] == OPC_MOV && ir[12:11] == OP_MOVR;
  assign is_alu  = ir[15:13] == OPC_ALU;
  assign is_cmp  = is_alu && ir[12:11] == OP_CMP;
  assign is_mvn  = is_alu && ir[12:11] == OP_MVN;
  assign legal   = is_movi || is_movr || is_alu;
  assign sximm5  = {{(DW-5){ir[4]}}, ir[4:0]};
  assign sximm8  = {{(DW-8){ir[7]}}, ir[7:0]};
endmodule

// File: rtl/datapath_ctrl.sv
// datapath_ctrl: Moore FSM and instruction register sequencing the datapath one instruction at a time.
module datapath_ctrl
  import ctrl_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s,
  input  logic [15:0]   in,
  output logic          w,
  output logic [2:0]    readnum,
  output logic [2:0]    writenum,
  output logic          write,
  output logic [1:0]    vsel,
  output logic          loada,
  output logic          loadb,
  output logic          asel,
  output logic          bsel,
  output logic [1:0]    shift,
  output logic [1:0]    ALUop,
  output logic          loadc,
  output logic          loads,
  output logic [DW-1:0] sximm5,
  output logic [DW-1:0] sximm8
);
  state_t      state, next;
  logic [15:0] ir;
  logic [2:0]  rn, rd, rm;
  logic        is_movi, is_movr, is_cmp, is_mvn, legal;

  ctrl_decode #(.DW(DW)) u_decode (
    .ir(ir), .rn(rn), .rd(rd), .rm(rm),
    .is_movi(is_movi), .is_movr(is_movr), .is_cmp(is_cmp), .is_mvn(is_mvn),
    .legal(legal), .sximm5(sximm5), .sximm8(sximm8)
  );

  assign shift = ir[4:3];
  assign ALUop = ir[12:11];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_WAIT;
      ir    <= '0;
    end else begin
      state <= next;
      if (state == S_WAIT && s) ir <= in;
    end
  end

  always_comb begin
    next     = S_WAIT;
    w        = 1'b0;
    readnum  = '0;
    writenum = '0;
    write    = 1'b0;
    vsel     = VSEL_C;
    loada    = 1'b0;
    loadb    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    case (state)
      S_WAIT: begin
        w    = 1'b1;
        next = s ? S_DECODE : S_WAIT;
      end
      S_DECODE: next = is_movi ? S_WIMM : (is_movr || is_mvn) ? S_GETB : legal ? S_GETA : S_WAIT;
      S_WIMM: begin
        vsel     = VSEL_IMM8;
        write    = 1'b1;
        writenum = rn;
      end
      S_GETA: begin
        readnum = rn;
        loada   = 1'b1;
        next    = S_GETB;
      end
      S_GETB: begin
        readnum = rm;
        loadb   = 1'b1;
        next    = S_EXEC;
      end
      S_EXEC: begin
        asel  = is_movr;
        loadc = !is_cmp;
        loads = !is_movr;
        next  = is_cmp ? S_WAIT : S_WREG;
      end
      S_WREG: begin
        write    = 1'b1;
        writenum = rd;
      end
      default: next = S_WAIT;
    endcase
  end
endmodule

// File: tb/tb_datapath_ctrl.sv
// tb_datapath_ctrl: scoreboard bench; expected per-cycle control vectors are queued on issue.
module tb_datapath_ctrl;
  typedef struct packed {
    logic       w;
    logic [2:0] readnum;
    logic [2:0] writenum;
    logic       write;
    logic [1:0] vsel;
    logic       loada;
    logic       loadb;
    logic       asel;
    logic       bsel;
    logic       loadc;
    logic       loads;
  } ctl_t;

  logic        clk = 0, reset = 1, s = 0;
  logic [15:0] in = '0;
  logic        w, write, loada, loadb, asel, bsel, loadc, loads;
  logic [2:0]  readnum, writenum;
  logic [1:0]  vsel, shift, ALUop;
  logic [15:0] sximm5, sximm8;
  int          compared = 0, mismatched = 0;
  ctl_t        q[$];

  datapath_ctrl #(.DW(16)) dut (
    .clk(clk), .reset(reset), .s(s), .in(in), .w(w),
    .readnum(readnum), .writenum(writenum), .write(write), .vsel(vsel),
    .loada(loada), .loadb(loadb), .asel(asel), .bsel(bsel),
    .shift(shift), .ALUop(ALUop), .loadc(loadc), .loads(loads),
    .sximm5(sximm5), .sximm8(sximm8)
  );

  always #5 clk = ~clk;

  localparam ctl_t IDLE = '{w: 1'b1, default: '0};
  localparam ctl_t BUSY = '{default: '0};

  function automatic ctl_t obs();
    return {w, readnum, writenum, write, vsel, loada, loadb, asel, bsel, loadc, loads};
  endfunction

  function automatic void push_instr(input logic [15:0] i);
    ctl_t c;
    logic [2:0] opc = i[15:13];
    logic [1:0] op = i[12:11];
    bit movi = opc == 3'b110 && op == 2'b10;
    bit movr = opc == 3'b110 && op == 2'b00;
    bit alu  = opc == 3'b101;
    bit cmp  = alu && op == 2'b01;
    bit mvn  = alu && op == 2'b11;
    q.push_back(BUSY);
    if (movi) begin
      c = BUSY; c.vsel = 2'd2; c.write = 1; c.writenum = i[10:8]; q.push_back(c);
    end else if (movr || alu) begin
      if (alu && !mvn) begin
        c = BUSY; c.readnum = i[10:8]; c.loada = 1; q.push_back(c);
      end
      c = BUSY; c.readnum = i[2:0]; c.loadb = 1; q.push_back(c);
      c = BUSY; c.asel = movr; c.loadc = !cmp; c.loads = !movr; q.push_back(c);
      if (!cmp) begin
        c = BUSY; c.write = 1; c.writenum = i[7:5]; q.push_back(c);
      end
    end
    q.push_back(IDLE);
  endfunction

  task automatic issue(input logic [15:0] i);
    @(negedge clk);
    in = i;
    s  = 1;
    push_instr(i);
  endtask

  task automatic drain(input int keep, input int limit);
    int n = 0;
    ctl_t e, o;
    while (q.size() > 0 && n < limit) begin
      @(negedge clk);
      e = q.pop_front();
      o = obs();
      compared++;
      if (o !== e) begin
        mismatched++;
        $display("FAIL ctl step %0d: got %h want %h", n, o, e);
      end
      n++;
      if (n >= keep) begin
        s = 0;
        if (!e.w) in = 16'($urandom);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      compared++;
      if (obs() !== IDLE) begin
        mismatched++;
        $display("FAIL reset_idle cycle %0d: got %h want %h", k, obs(), IDLE);
      end
    end
    compared++;
    if (sximm8 !== 16'h0000 || shift !== 2'b00) begin
      mismatched++;
      $display("FAIL reset_ir: sximm8 %h shift %b want 0000 00", sximm8, shift);
    end
  endtask

  task automatic test_mov_imm();
    issue(16'hD007);
    drain(1, 100);
    compared++;
    if (sximm8 !== 16'h0007) begin
      mismatched++;
      $display("FAIL movi_imm8_pos: got %h want 0007", sximm8);
    end
    issue(16'hD0F9);
    drain(1, 100);
    compared++;
    if (sximm8 !== 16'hFFF9) begin
      mismatched++;
      $display("FAIL movi_imm8_neg: got %h want fff9", sximm8);
    end
  endtask

  task automatic test_mov_reg();
    issue(16'hC028);
    drain(1, 100);
    compared++;
    if (shift !== 2'b01 || sximm5 !== 16'h0008) begin
      mismatched++;
      $display("FAIL movr_fields: shift %b sximm5 %h want 01 0008", shift, sximm5);
    end
    issue(16'hB820);
    drain(1, 100);
    compared++;
    if (ALUop !== 2'b11) begin
      mismatched++;
      $display("FAIL mvn_aluop: got %b want 11", ALUop);
    end
  endtask

  task automatic test_back_to_back();
    issue(16'hA140);
    push_instr(16'hA140);
    drain(7, 100);
    compared++;
    if (ALUop !== 2'b00) begin
      mismatched++;
      $display("FAIL add_aluop: got %b want 00", ALUop);
    end
  endtask

  task automatic test_cmp_illegal();
    issue(16'hA900);
    drain(1, 100);
    compared++;
    if (ALUop !== 2'b01) begin
      mismatched++;
      $display("FAIL cmp_aluop: got %b want 01", ALUop);
    end
    issue(16'hE000);
    drain(1, 100);
  endtask

  task automatic test_reset_mid();
    issue(16'hA140);
    drain(1, 3);
    reset = 1;
    @(negedge clk);
    reset = 0;
    compared++;
    if (obs() !== IDLE) begin
      mismatched++;
      $display("FAIL reset_mid: got %h want %h", obs(), IDLE);
    end
    q.delete();
    issue(16'hD305);
    drain(1, 100);
    compared++;
    if (sximm8 !== 16'h0005) begin
      mismatched++;
      $display("FAIL post_reset_movi: got %h want 0005", sximm8);
    end
  endtask

  initial begin
    test_reset();
    test_mov_imm();
    test_mov_reg();
    test_back_to_back();
    test_cmp_illegal();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/datapath_ctrl.md
Name: datapath_ctrl

Overview:
- Moore FSM plus instruction latch that sequences the datapath for one instruction at a time.
- Decodes MOV-immediate, MOV-register, ADD, CMP, AND and MVN.
- Drives the datapath's register-file, A/B/C load, mux-select and status-load controls.
- Sits between the instruction source (upstream `s`/`w` handshake) and the datapath. The PC and mdata paths are never selected.

Parameters:
- DW, 16, datapath width; width of `sximm5` and `sximm8`.

Ports:
- clk      in   1   rising-edge clock
- reset    in   1   synchronous, active-high reset
- s        in   1   start request; sampled only in WAIT
- in       in   16  instruction word; captured on accept
- w        out  1   1 = idle, ready to accept
- readnum  out  3   register-file read address
- writenum out  3   register-file write address
- write    out  1   register-file write enable
- vsel     out  2   writeback select: 0=C, 1=PC, 2=sximm8, 3=mdata
- loada    out  1   load A
- loadb    out  1   load B
- asel     out  1   1 = A operand forced to 0
- bsel     out  1   1 = B operand from sximm5
- shift    out  2   shifter op, from latched instruction [4:3]
- ALUop    out  2   ALU op, from latched instruction [12:11]
- loadc    out  1   load C
- loads    out  1   load status (Z)
- sximm5   out  DW  sign-extended instruction [4:0]
- sximm8   out  DW  sign-extended instruction [7:0]

Behaviour:
- Instruction fields:
  - opcode [15:13], op [12:11], Rn [10:8], Rd [7:5], sh [4:3], Rm [2:0].
  - Legal encodings:
    - 110/10 MOV Rn,#imm8
    - 110/00 MOV Rd,Rm{,sh}
    - 101/00 ADD Rd,Rn,Rm{,sh}
    - 101/01 CMP Rn,Rm{,sh}
    - 101/10 AND Rd,Rn,Rm{,sh}
    - 101/11 MVN Rd,Rm{,sh}
  - Everything else is illegal.
- Instruction register:
  - IR loads `in` on the edge where state=WAIT and s=1; it is held otherwise.
  - All field-derived outputs come from IR, never from `in`.
- Reset:
  - On the reset edge: state goes to WAIT and IR clears to 0.
  - Reset wins over s and over any state.
  - After reset: w=1; write, loada, loadb, loadc, loads, asel and bsel are 0; vsel=0; readnum=writenum=0.
- Control outputs are Moore outputs (function of state and IR) and default to 0 in every state unless listed.
- States and transitions:
  - WAIT: w=1. If s → DECODE, else stay.
  - DECODE: no control asserted.
    - MOV imm → WIMM
    - MOV reg → GETB
    - MVN → GETB
    - ADD, CMP, AND → GETA
    - illegal → WAIT (no register or status side effect)
  - WIMM: vsel=2, write=1, writenum=Rn → WAIT.
  - GETA: readnum=Rn, loada=1 → GETB.
  - GETB: readnum=Rm, loadb=1 → EXEC.
  - EXEC:
    - asel=1 for MOV reg; asel=0 for all others.
    - bsel=0.
    - CMP: loads=1, loadc=0 → WAIT.
    - Otherwise: loadc=1, and loads=1 for ADD/AND/MVN → WREG.
  - WREG: vsel=0, write=1, writenum=Rd → WAIT.
- Busy (w=0) cycle counts from the accept edge:
  - MOV imm: 2
  - MOV reg: 4
  - MVN: 4
  - CMP: 4
  - ADD/AND: 5
  - illegal: 1
- Handshake:
  - s is level-sensitive. If s is still 1 when WAIT is re-entered, the next instruction is accepted on the following edge, with no idle gap beyond the single WAIT cycle.
  - s is ignored outside WAIT.
  - `in` may change freely while w=0.
- Reset mid-instruction: the state returns to WAIT, and no write or loadc is asserted in the cycle after reset.
- The datapath's own A/B/C/status contents are not cleared by this block.
- State encoding is binary (3 bits). Unused codes go to WAIT on the next edge.

Decomposition:
- Package ctrl_pkg:
  - state encodings
  - opcode/op constants (OPC_MOV=3'b110, OPC_ALU=3'b101)
  - vsel codes (VSEL_C, VSEL_PC, VSEL_IMM8, VSEL_MDATA)
- Sub-module ctrl_decode: combinational field extraction, legality flag and sign extension of imm5/imm8 to DW.
- The FSM and IR stay in datapath_ctrl.

Test Plan:
- Reset, then idle: reset=1 for one edge, then s=0 → w=1, all enables 0, state stays WAIT for 10 cycles.
- MOV R0,#7: in=16'hD007, pulse s →
  - w=0 for 2 cycles;
  - the WIMM cycle has vsel=2, write=1, writenum=0, sximm8=16'h0007.
  - Repeat with in=16'hD0F9 → sximm8=16'hFFF9.
- MOV R1,R0 LSL#1: in=16'hC028 →
  - GETB: readnum=0, loadb=1;
  - EXEC: asel=1, shift=2'b01, loadc=1;
  - WREG: write=1, writenum=1, vsel=0;
  - 4 busy cycles.
- ADD R2,R1,R0 with s held high: in=16'hA140 →
  - GETA readnum=1, GETB readnum=0, EXEC loadc=1 and loads=1, WREG writenum=2;
  - 5 busy cycles, one WAIT cycle, immediate re-accept.
- CMP R1,R0 in=16'hA900, then illegal in=16'hE000:
  - CMP: EXEC has loads=1, loadc=0, write never 1; 4 busy cycles.
  - Illegal: 1 busy cycle, no enable asserted.
- Reset during GETB of ADD (in=16'hA140): the next cycle has w=1 and write=loadc=0, and a subsequent MOV R3,#5 (16'hD305) completes correctly.
